// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, reset default, opcodes and fetch entry type
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [6:0] {
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        AUIPC  = 7'b0010111,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        LUI    = 7'b0110111,
        BRANCH = 7'b1100011,
        JALR   = 7'b1100111,
        JAL    = 7'b1101111
    } opcode_e;

    // One prefetched word together with the word address it was read from.
    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [INST_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_if.sv
// rtl/riscv_fetch_if.sv - instruction memory and core-side signals of the fetch stage
interface riscv_fetch_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]   imem_addr;
    logic              imem_req;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   inst_addr;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect;
    logic [XLEN-1:0]   redirect_addr;
    logic              err;

    modport master (
        output imem_addr, imem_req,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst, inst_addr, inst_valid,
        input  inst_ready, redirect, redirect_addr,
        output err
    );

    modport slave (
        input  imem_addr, imem_req,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst, inst_addr, inst_valid,
        output inst_ready, redirect, redirect_addr,
        input  err
    );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - in-order prefetch FIFO with flush and a registered head entry
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  fetch_entry_t         push_data_i,
    input  logic                 pop_i,
    output fetch_entry_t         head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head_q, head_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_en, push_en;

    assign pop_en  = pop_i && (count_q != '0);
    assign push_en = push_i && ((count_q != CW'(DEPTH)) || pop_en);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    // Next head: the word being written lands at the head when it is the only entry.
    always_comb begin
        head_d = '0;
        if (!flush_i && (count_d != '0)) begin
            if (push_en && (rd_ptr_d == wr_ptr_q)) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch.sv
// rtl/riscv_fetch.sv - credit-limited instruction fetch with prefetch buffer and redirect flush
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    riscv_fetch_if.master      bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_addr_q, resp_addr_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            err_q, err_d;
    logic            rst_d_q;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     inflight;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_data;
    logic            req, accept, rsp_ok, spurious, push, pop;

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req      = !rst && !rst_d_q && !bus.redirect && (inflight < (CW+1)'(DEPTH));
    assign accept   = req && bus.imem_gnt;
    assign rsp_ok   = bus.imem_rvalid && (outstanding_q != '0);
    assign spurious = bus.imem_rvalid && (outstanding_q == '0);
    assign push     = rsp_ok && (discard_q == '0) && !bus.redirect;
    assign pop      = (fifo_count != '0) && bus.inst_ready && !bus.redirect;

    assign push_data.addr = resp_addr_q;
    assign push_data.data = bus.imem_rdata;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_addr_d   = resp_addr_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);
        discard_d     = discard_q;
        err_d         = err_q || spurious;
        if (bus.redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc_d  = bus.redirect_addr;
            resp_addr_d = bus.redirect_addr;
            discard_d   = outstanding_q - CW'(rsp_ok);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (rsp_ok && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if (push) begin
                resp_addr_d = resp_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_addr_q   <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            err_q         <= 1'b0;
            rst_d_q       <= 1'b1;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_addr_q   <= resp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            err_q         <= err_d;
            rst_d_q       <= 1'b0;
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus.redirect),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign bus.imem_addr  = fetch_pc_q;
    assign bus.imem_req   = req;
    assign bus.inst       = fifo_head.data;
    assign bus.inst_addr  = fifo_head.addr;
    assign bus.inst_valid = (fifo_count != '0);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// tb/tb_riscv_fetch.sv - directed scoreboard bench for riscv_fetch with an in-order memory model
module tb_riscv_fetch;
    import riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    riscv_fetch_if bus ();

    riscv_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  grant_log[$];
    int           cyc, lat, n_assert, n_fail, n_pop;
    logic         s_req;
    logic         full_push_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 32'(i);
            e.data = 32'h0000_0013 + e.addr;
            exp_q.push_back(e);
        end
    endtask

    // One clock: sample before the edge, advance the memory model after it.
    task automatic step();
        logic         acc, rsp;
        logic [31:0]  a;
        fetch_entry_t want;
        #1;
        s_req = bus.imem_req;
        a     = bus.imem_addr;
        acc   = bus.imem_req && bus.imem_gnt;
        rsp   = bus.imem_rvalid;
        if (dut.u_fifo.push_i && (32'(dut.u_fifo.count_o) == DEPTH)) full_push_seen = 1'b1;
        if (bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pop: observed inst_addr %h expected no pop", bus.inst_addr);
                end
            end else begin
                want = exp_q.pop_front();
                chk("inst_addr", bus.inst_addr, want.addr);
                chk("inst", bus.inst, want.data);
            end
        end
        @(posedge clk);
        cyc++;
        if (rsp && (pend.size() != 0)) void'(pend.pop_front());
        if (acc) begin
            grant_log.push_back(a);
            pend.push_back('{a, cyc + lat});
        end
        #1;
        if ((pend.size() != 0) && (pend[0].due <= cyc + 1)) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'h0000_0013 + pend[0].addr;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_gnt      = 1'b0;
        bus.inst_ready    = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        step();
        step();
        pend.delete();
        exp_q.delete();
        grant_log.delete();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_addr = '0;
        cyc = 0; lat = 1; n_assert = 0; n_fail = 0; n_pop = 0; full_push_seen = 1'b0;

        // Reset state
        do_reset();
        chk("rst_imem_req", 32'(bus.imem_req), 0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_inst_addr", bus.inst_addr, 0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_err", 32'(bus.err), 0);

        // Streaming with one-cycle memory
        lat = 1; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        push_exp(32'h0, 16);
        step(); step();
        chk("startup_valid_lo", 32'(bus.inst_valid), 0);
        step();
        chk("startup_valid_hi", 32'(bus.inst_valid), 1);
        chk("startup_addr", bus.inst_addr, 0);
        n_pop = 0;
        repeat (8) step();
        chk("stream_pops", n_pop, 8);
        chk("stream_next", exp_q[0].addr, 8);
        chk("stream_err", 32'(bus.err), 0);
        bus.inst_ready = 1'b0;

        // Back-pressure fills exactly DEPTH entries
        do_reset();
        lat = 1; bus.imem_gnt = 1'b1;
        repeat (10) step();
        chk("bp_grants", grant_log.size(), DEPTH);
        chk("bp_last_grant", grant_log[3], 3);
        chk("bp_req_low", 32'(bus.imem_req), 0);
        chk("bp_count", 32'(dut.u_fifo.count_o), DEPTH);
        chk("bp_imem_addr", bus.imem_addr, 4);
        grant_log.delete();
        push_exp(32'h0, 12);
        n_pop = 0; bus.inst_ready = 1'b1;
        repeat (6) step();
        chk("bp_resume_addr", grant_log[0], 4);
        chk("bp_pops", n_pop, 6);
        bus.inst_ready = 1'b0;

        // Redirect with three requests in flight
        do_reset();
        lat = 4; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        repeat (4) step();
        chk("rd_grants", grant_log.size(), 3);
        chk("rd_outstanding", 32'(dut.outstanding_q), 3);
        bus.redirect = 1'b1; bus.redirect_addr = 32'h100;
        grant_log.delete();
        step();
        chk("rd_req_blocked", 32'(s_req), 0);
        chk("rd_discard", 32'(dut.discard_q), 3);
        chk("rd_flush_valid", 32'(bus.inst_valid), 0);
        chk("rd_imem_addr", bus.imem_addr, 32'h100);
        bus.redirect = 1'b0;
        push_exp(32'h100, 8);
        n_pop = 0;
        repeat (12) step();
        chk("rd_first_grant", grant_log[0], 32'h100);
        chk("rd_pops_seen", 32'(n_pop != 0), 1);
        chk("rd_discard_done", 32'(dut.discard_q), 0);
        chk("rd_err", 32'(bus.err), 0);

        // Redirect coinciding with a response and a pop
        do_reset();
        lat = 2; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        repeat (4) step();
        chk("rdp_valid", 32'(bus.inst_valid), 1);
        chk("rdp_head", bus.inst_addr, 0);
        chk("rdp_outstanding", 32'(dut.outstanding_q), 2);
        bus.redirect = 1'b1; bus.redirect_addr = 32'h200;
        step();
        chk("rdp_flushed", 32'(bus.inst_valid), 0);
        chk("rdp_discard", 32'(dut.discard_q), 1);
        chk("rdp_outstanding_after", 32'(dut.outstanding_q), 1);
        chk("rdp_err", 32'(bus.err), 0);
        bus.redirect = 1'b0;
        push_exp(32'h200, 16);
        n_pop = 0;
        repeat (10) step();
        chk("rdp_pops_seen", 32'(n_pop != 0), 1);
        chk("rdp_discard_done", 32'(dut.discard_q), 0);

        // Address wrap at the top of the word space
        bus.redirect = 1'b1; bus.redirect_addr = 32'hFFFF_FFFE;
        step();
        exp_q.delete(); grant_log.delete();
        bus.redirect = 1'b0;
        push_exp(32'hFFFF_FFFE, 8);
        n_pop = 0;
        repeat (10) step();
        chk("wrap_grant0", grant_log[0], 32'hFFFF_FFFE);
        chk("wrap_grant1", grant_log[1], 32'hFFFF_FFFF);
        chk("wrap_grant2", grant_log[2], 32'h0000_0000);
        chk("wrap_pops_seen", 32'(n_pop >= 3), 1);
        chk("wrap_err", 32'(bus.err), 0);
        bus.inst_ready = 1'b0;

        // Spurious response while idle
        do_reset();
        repeat (3) step();
        chk("spur_err_before", 32'(bus.err), 0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("spur_err", 32'(bus.err), 1);
        chk("spur_valid", 32'(bus.inst_valid), 0);
        chk("spur_outstanding", 32'(dut.outstanding_q), 0);
        repeat (2) step();
        chk("spur_sticky", 32'(bus.err), 1);
        chk("spur_valid_later", 32'(bus.inst_valid), 0);
        do_reset();
        chk("rst_clears_err", 32'(bus.err), 0);

        // Reset with two requests in flight
        lat = 5;
        step();
        bus.imem_gnt = 1'b1;
        step(); step();
        bus.imem_gnt = 1'b0;
        chk("mid_outstanding", 32'(dut.outstanding_q), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend.delete(); grant_log.delete(); exp_q.delete();
        bus.imem_rvalid = 1'b0;
        chk("mid_rst_outstanding", 32'(dut.outstanding_q), 0);
        chk("mid_rst_count", 32'(dut.u_fifo.count_o), 0);
        chk("mid_rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("mid_rst_valid", 32'(bus.inst_valid), 0);
        chk("mid_rst_req", 32'(bus.imem_req), 0);
        lat = 1; bus.imem_gnt = 1'b1; bus.inst_ready = 1'b1;
        push_exp(RESET_PC, 16);
        n_pop = 0;
        repeat (8) step();
        chk("mid_restart_grant", grant_log[0], RESET_PC);
        chk("mid_restart_pops", n_pop, 5);
        chk("mid_restart_err", 32'(bus.err), 0);

        chk("no_push_when_full", 32'(full_push_seen), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
